// File: rtl/f1_light_seq.sv
// Start-light sequencer: fills a light bar one lamp per enabled cycle, holds it
// for a programmable time, then clears and pulses done.
module f1_light_seq #(
    parameter int WIDTH   = 8,
    parameter int DELAY_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               trigger,
    input  logic               mode,
    input  logic [DELAY_W-1:0] delay,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               cmd_delay,
    output logic               done
);

    // state | meaning
    // IDLE  | bar dark, waiting for trigger (mode=1) or en (mode=0)
    // LIGHT | one lamp added per en cycle until the bar is full
    // HOLD  | bar full, counter runs down from the sampled delay
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIGHT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [DELAY_W-1:0] cnt_q;
    logic               done_q;
    logic               busy_q;
    logic               cmd_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cmd_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((mode && trigger) || (!mode && en)) begin
                        state_q <= LIGHT;
                        busy_q  <= 1'b1;
                    end
                end
                LIGHT: begin
                    if (en) begin
                        if (data_q != ALL_ONES) begin
                            data_q <= {data_q[WIDTH-2:0], 1'b1};
                        end else begin
                            state_q <= HOLD;
                            cnt_q   <= delay;
                            cmd_q   <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Terminal count leaves the counter parked at zero, so it never wraps.
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        data_q  <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cmd_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    data_q  <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    cmd_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign busy      = busy_q;
    assign cmd_delay = cmd_q;
    assign done      = done_q;

endmodule

// File: tb/tb_f1_light_seq.sv
// Bench for f1_light_seq: a behavioural lamp-count model feeds a scoreboard
// queue, plus directed measurements of hold length and loop period.
module tb_f1_light_seq;

    localparam int WIDTH   = 8;
    localparam int DELAY_W = 7;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               trigger = 1'b0;
    logic               mode = 1'b0;
    logic [DELAY_W-1:0] delay = '0;
    logic [WIDTH-1:0]   data_out;
    logic               busy;
    logic               cmd_delay;
    logic               done;

    f1_light_seq #(.WIDTH(WIDTH), .DELAY_W(DELAY_W)) dut (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .mode(mode),
        .delay(delay), .data_out(data_out), .busy(busy),
        .cmd_delay(cmd_delay), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             busy;
        logic             cmd;
        logic             done;
    } exp_t;

    exp_t sb[$];
    int   done_cyc[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   hold_run  = 0;
    int   last_hold = 0;

    // model: 0 = idle, 1 = lighting, 2 = holding; m_rem = hold cycles still to run
    int m_state = 0;
    int m_lit   = 0;
    int m_rem   = 0;
    bit m_done  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic tick();
        exp_t e;
        m_done = 1'b0;
        if (!rst) begin
            m_state = 0; m_lit = 0; m_rem = 0;
        end else begin
            case (m_state)
                0: if (mode ? trigger : en) m_state = 1;
                1: if (en) begin
                       if (m_lit < WIDTH) m_lit++;
                       else begin m_state = 2; m_rem = int'(delay) + 1; end
                   end
                default: begin
                    m_rem--;
                    if (m_rem == 0) begin m_state = 0; m_lit = 0; m_done = 1'b1; end
                end
            endcase
        end
        e.data = WIDTH'((64'd1 << m_lit) - 64'd1);
        e.busy = (m_state != 0);
        e.cmd  = (m_state == 2);
        e.done = m_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("data_out", 32'(data_out), 32'(e.data));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("cmd_delay", 32'(cmd_delay), 32'(e.cmd));
        chk("done", 32'(done), 32'(e.done));
        if (cmd_delay) hold_run++;
        if (done) begin
            last_hold = hold_run;
            hold_run  = 0;
            done_cyc.push_back(cyc);
        end
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        do begin tick(); n++; end while (!done && n < budget);
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_cmd(input int budget);
        int n = 0;
        do begin tick(); n++; end while (!cmd_delay && n < budget);
        if (!cmd_delay) chk("hold_timeout", 32'(cmd_delay), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();

        // one-shot, delay=3
        mode = 1'b1; delay = 7'd3; en = 1'b1; trigger = 1'b1;
        hold_run = 0;
        tick();
        trigger = 1'b0;
        run_until_done(40);
        chk("hold_len_d3", 32'(last_hold), 32'd4);
        chk("idle_after_done", 32'(busy), 32'd0);
        tick();

        // en gating at 07
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (3) tick();
        chk("gate_pre", 32'(data_out), 32'h07);
        en = 1'b0;
        repeat (5) tick();
        chk("gate_hold", 32'(data_out), 32'h07);
        chk("gate_busy", 32'(busy), 32'd1);
        en = 1'b1;
        tick();
        chk("gate_next", 32'(data_out), 32'h0F);
        run_until_done(40);

        // auto loop, delay=0
        mode = 1'b0; delay = 7'd0; en = 1'b1;
        done_cyc.delete();
        hold_run = 0;
        repeat (40) tick();
        chk("loop_dones", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() >= 3) begin
            chk("loop_period1", 32'(done_cyc[1] - done_cyc[0]), 32'd11);
            chk("loop_period2", 32'(done_cyc[2] - done_cyc[1]), 32'd11);
        end
        chk("hold_len_d0", 32'(last_hold), 32'd1);
        en = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1;

        // reset mid-HOLD with counter at 50, trigger during reset not remembered
        mode = 1'b1; delay = 7'd100; en = 1'b1; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        wait_cmd(40);
        repeat (50) tick();
        chk("pre_rst_cmd", 32'(cmd_delay), 32'd1);
        rst = 1'b0; trigger = 1'b1;
        tick();
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_cmd", 32'(cmd_delay), 32'd0);
        rst = 1'b1; trigger = 1'b0;
        repeat (10) tick();
        chk("stay_idle", 32'(busy), 32'd0);

        // delay sampled at HOLD entry only, mode ignored outside IDLE
        hold_run = 0;
        delay = 7'd10; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (3) begin mode = ~mode; tick(); end
        mode = 1'b1;
        wait_cmd(40);
        delay = 7'd2; en = 1'b0; mode = 1'b0;
        repeat (3) tick();
        mode = 1'b1;
        run_until_done(40);
        chk("hold_len_d10", 32'(last_hold), 32'd11);

        // delay=127, stray triggers while busy
        hold_run = 0;
        delay = 7'd127; en = 1'b1; trigger = 1'b1;
        tick();
        for (int i = 0; i < 250 && !done; i++) begin
            trigger = ((i % 10) == 3);
            tick();
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
        chk("hold_len_d127", 32'(last_hold), 32'd128);
        trigger = 1'b0;
        repeat (20) tick();
        chk("no_extra_seq", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
